// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter over eight requesters that owns one grant at a time
// and steers the owner's data bit through a 2:1-tree 8:1 mux.
// A grant ends on release, on the owner dropping its request, or when
// MAX_HOLD cycles have elapsed. Every grant is followed by exactly one
// IDLE cycle before the next arbitration.
// The owner-finished input is named release_i because "release" is a
// reserved word in SystemVerilog.
module mux_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       release_i,
    input  logic [7:0] in,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       valid,
    output logic       out
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Terminal value of hold_cnt: reaching it ends the grant at that edge.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] sel_q, sel_d;
    logic       valid_q, valid_d;
    logic [2:0] last_q, last_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;

    // Candidate k is last+1+k (mod 8), so candidate 0 has the highest
    // priority and the previous owner (candidate 7) has the lowest.
    logic [2:0] cand_idx [8];
    logic [7:0] cand_hit;

    for (genvar gi = 0; gi < 8; gi++) begin : g_cand
        assign cand_idx[gi] = last_q + 3'(gi + 1);
        assign cand_hit[gi] = req[cand_idx[gi]];
    end

    logic [2:0] win_idx;

    // Priority pick: scanning from the lowest-priority candidate upward
    // leaves the highest-priority hit as the winner.
    always_comb begin
        win_idx = cand_idx[0];
        for (int k = 7; k >= 0; k--) begin
            if (cand_hit[k]) begin
                win_idx = cand_idx[k];
            end
        end
    end

    logic terminate;
    assign terminate = release_i | ~req[sel_q] | (hold_cnt_q == HOLD_LAST);

    // Next-state and registered-output computation for the IDLE/GRANT FSM.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        valid_d    = valid_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                grant_d = 8'h00;
                valid_d = 1'b0;
                if (|req) begin
                    state_d    = GRANT;
                    grant_d    = 8'h01 << win_idx;
                    sel_d      = win_idx;
                    valid_d    = 1'b1;
                    last_d     = win_idx;
                    hold_cnt_d = 8'h00;
                end
            end
            GRANT: begin
                if (terminate) begin
                    // Arbitration is deferred to the following IDLE cycle
                    // even when new requests are already pending.
                    state_d = IDLE;
                    grant_d = 8'h00;
                    valid_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 8'h00;
                valid_d = 1'b0;
            end
        endcase
    end

    // State register; reset wins over every other input and points last at
    // requester 7 so the first search after reset starts at requester 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= 8'h00;
            sel_q      <= 3'd0;
            valid_q    <= 1'b0;
            last_q     <= 3'd7;
            hold_cnt_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // 8:1 data mux built as three levels of 2:1 muxes on sel bits 0,1,2.
    logic [3:0] mux_l1;
    logic [1:0] mux_l2;
    logic       mux_l3;

    for (genvar gi = 0; gi < 4; gi++) begin : g_mux_l1
        assign mux_l1[gi] = sel_q[0] ? in[2*gi+1] : in[2*gi];
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_mux_l2
        assign mux_l2[gi] = sel_q[1] ? mux_l1[2*gi+1] : mux_l1[2*gi];
    end

    assign mux_l3 = sel_q[2] ? mux_l2[1] : mux_l2[0];

    assign grant = grant_q;
    assign sel   = sel_q;
    assign valid = valid_q;
    assign out   = valid_q & mux_l3;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter built with MAX_HOLD=4; every scenario
// starts from reset and compares {grant, sel, valid, out} against
// hand-computed values one time unit after each rising edge.
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       release_i;
    logic [7:0] in;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       valid;
    logic       out;

    int checks = 0;
    int errors = 0;

    logic [7:0] eg;
    logic [2:0] es;
    logic       ev;
    logic       eo;

    mux_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .release_i (release_i),
        .in        (in),
        .grant     (grant),
        .sel       (sel),
        .valid     (valid),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 8'h00; release_i = 1'b0; in = 8'h00;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 8'hFF; release_i = 1'b0; in = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            eg = 8'h00; es = 3'd0; ev = 1'b0; eo = 1'b0;
            checks++;
            if ({grant, sel, valid, out} !== {eg, es, ev, eo}) begin
                errors++;
                $display("FAIL reset[%0d]: got grant=%h sel=%0d valid=%b out=%b, want grant=%h sel=%0d valid=%b out=%b",
                         i, grant, sel, valid, out, eg, es, ev, eo);
            end
        end
        rst = 1'b0; req = 8'h00; in = 8'h00;
        $display("test_reset done");
    endtask

    task automatic test_v1();
        do_reset();
        req = 8'h01; in = 8'h01;
        tick();
        eg = 8'h01; es = 3'd0; ev = 1'b1; eo = 1'b1;
        checks++;
        if ({grant, sel, valid, out} !== {eg, es, ev, eo}) begin
            errors++;
            $display("FAIL v1_first_grant: got grant=%h sel=%0d valid=%b out=%b, want grant=%h sel=%0d valid=%b out=%b",
                     grant, sel, valid, out, eg, es, ev, eo);
        end
        $display("test_v1 done");
    endtask

    task automatic test_v2();
        logic [7:0] pat;
        int         o;
        do_reset();
        pat = 8'hA5; in = pat; req = 8'hFF; release_i = 1'b0;
        for (int n = 0; n < 9; n++) begin
            o = n % 8;
            for (int c = 0; c < 4; c++) begin
                tick();
                eg = 8'h01 << o; es = 3'(o); ev = 1'b1; eo = pat[o];
                checks++;
                if ({grant, sel, valid, out} !== {eg, es, ev, eo}) begin
                    errors++;
                    $display("FAIL v2_hold n=%0d c=%0d: got grant=%h sel=%0d valid=%b out=%b, want grant=%h sel=%0d valid=%b out=%b",
                             n, c, grant, sel, valid, out, eg, es, ev, eo);
                end
            end
            tick();
            eg = 8'h00; es = 3'(o); ev = 1'b0; eo = 1'b0;
            checks++;
            if ({grant, sel, valid, out} !== {eg, es, ev, eo}) begin
                errors++;
                $display("FAIL v2_idle n=%0d: got grant=%h sel=%0d valid=%b out=%b, want grant=%h sel=%0d valid=%b out=%b",
                         n, grant, sel, valid, out, eg, es, ev, eo);
            end
        end
        req = 8'h00;
        $display("test_v2 done");
    endtask

    task automatic test_v3();
        do_reset();
        req = 8'h28; in = 8'h20;
        for (int c = 0; c < 2; c++) begin
            tick();
            eg = 8'h08; es = 3'd3; ev = 1'b1; eo = 1'b0;
            checks++;
            if ({grant, sel, valid, out} !== {eg, es, ev, eo}) begin
                errors++;
                $display("FAIL v3_owner3 c=%0d: got grant=%h sel=%0d valid=%b out=%b, want grant=%h sel=%0d valid=%b out=%b",
                         c, grant, sel, valid, out, eg, es, ev, eo);
            end
        end
        req = 8'h22;
        tick();
        eg = 8'h00; es = 3'd3; ev = 1'b0; eo = 1'b0;
        checks++;
        if ({grant, sel, valid, out} !== {eg, es, ev, eo}) begin
            errors++;
            $display("FAIL v3_drop_idle: got grant=%h sel=%0d valid=%b out=%b, want grant=%h sel=%0d valid=%b out=%b",
                     grant, sel, valid, out, eg, es, ev, eo);
        end
        tick();
        eg = 8'h20; es = 3'd5; ev = 1'b1; eo = 1'b1;
        checks++;
        if ({grant, sel, valid, out} !== {eg, es, ev, eo}) begin
            errors++;
            $display("FAIL v3_next_owner: got grant=%h sel=%0d valid=%b out=%b, want grant=%h sel=%0d valid=%b out=%b",
                     grant, sel, valid, out, eg, es, ev, eo);
        end
        req = 8'h00;
        $display("test_v3 done");
    endtask

    task automatic test_v4();
        int o;
        do_reset();
        req = 8'h81; in = 8'h80; release_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            o = (i % 2 == 1) ? 7 : 0;
            tick();
            eg = 8'h01 << o; es = 3'(o); ev = 1'b1; eo = (o == 7);
            checks++;
            if ({grant, sel, valid, out} !== {eg, es, ev, eo}) begin
                errors++;
                $display("FAIL v4_grant i=%0d: got grant=%h sel=%0d valid=%b out=%b, want grant=%h sel=%0d valid=%b out=%b",
                         i, grant, sel, valid, out, eg, es, ev, eo);
            end
            tick();
            eg = 8'h00; es = 3'(o); ev = 1'b0; eo = 1'b0;
            checks++;
            if ({grant, sel, valid, out} !== {eg, es, ev, eo}) begin
                errors++;
                $display("FAIL v4_idle i=%0d: got grant=%h sel=%0d valid=%b out=%b, want grant=%h sel=%0d valid=%b out=%b",
                         i, grant, sel, valid, out, eg, es, ev, eo);
            end
        end
        release_i = 1'b0; req = 8'h00;
        $display("test_v4 done");
    endtask

    task automatic test_v5();
        do_reset();
        req = 8'h20; in = 8'hFF;
        for (int c = 0; c < 2; c++) begin
            tick();
            eg = 8'h20; es = 3'd5; ev = 1'b1; eo = 1'b1;
            checks++;
            if ({grant, sel, valid, out} !== {eg, es, ev, eo}) begin
                errors++;
                $display("FAIL v5_owner5 c=%0d: got grant=%h sel=%0d valid=%b out=%b, want grant=%h sel=%0d valid=%b out=%b",
                         c, grant, sel, valid, out, eg, es, ev, eo);
            end
        end
        rst = 1'b1; req = 8'hFF;
        tick();
        eg = 8'h00; es = 3'd0; ev = 1'b0; eo = 1'b0;
        checks++;
        if ({grant, sel, valid, out} !== {eg, es, ev, eo}) begin
            errors++;
            $display("FAIL v5_mid_reset: got grant=%h sel=%0d valid=%b out=%b, want grant=%h sel=%0d valid=%b out=%b",
                     grant, sel, valid, out, eg, es, ev, eo);
        end
        rst = 1'b0;
        tick();
        eg = 8'h01; es = 3'd0; ev = 1'b1; eo = 1'b1;
        checks++;
        if ({grant, sel, valid, out} !== {eg, es, ev, eo}) begin
            errors++;
            $display("FAIL v5_first_after_reset: got grant=%h sel=%0d valid=%b out=%b, want grant=%h sel=%0d valid=%b out=%b",
                     grant, sel, valid, out, eg, es, ev, eo);
        end
        req = 8'h00;
        $display("test_v5 done");
    endtask

    task automatic test_v6();
        do_reset();
        req = 8'h04; in = 8'h04;
        for (int c = 0; c < 2; c++) begin
            tick();
            eg = 8'h04; es = 3'd2; ev = 1'b1; eo = 1'b1;
            checks++;
            if ({grant, sel, valid, out} !== {eg, es, ev, eo}) begin
                errors++;
                $display("FAIL v6_owner2 c=%0d: got grant=%h sel=%0d valid=%b out=%b, want grant=%h sel=%0d valid=%b out=%b",
                         c, grant, sel, valid, out, eg, es, ev, eo);
            end
        end
        release_i = 1'b1; req = 8'h95; in = 8'h10;
        tick();
        eg = 8'h00; es = 3'd2; ev = 1'b0; eo = 1'b0;
        checks++;
        if ({grant, sel, valid, out} !== {eg, es, ev, eo}) begin
            errors++;
            $display("FAIL v6_release_idle: got grant=%h sel=%0d valid=%b out=%b, want grant=%h sel=%0d valid=%b out=%b",
                     grant, sel, valid, out, eg, es, ev, eo);
        end
        release_i = 1'b0;
        tick();
        eg = 8'h10; es = 3'd4; ev = 1'b1; eo = 1'b1;
        checks++;
        if ({grant, sel, valid, out} !== {eg, es, ev, eo}) begin
            errors++;
            $display("FAIL v6_rr_winner: got grant=%h sel=%0d valid=%b out=%b, want grant=%h sel=%0d valid=%b out=%b",
                     grant, sel, valid, out, eg, es, ev, eo);
        end
        in = 8'hEF;
        #1;
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("FAIL v6_out_track_low: got out=%b, want out=0", out);
        end
        in = 8'h10;
        #1;
        checks++;
        if (out !== 1'b1) begin
            errors++;
            $display("FAIL v6_out_track_high: got out=%b, want out=1", out);
        end
        release_i = 1'b1; in = 8'hFF;
        tick();
        eg = 8'h00; es = 3'd4; ev = 1'b0; eo = 1'b0;
        checks++;
        if ({grant, sel, valid, out} !== {eg, es, ev, eo}) begin
            errors++;
            $display("FAIL v6_out_zero_idle: got grant=%h sel=%0d valid=%b out=%b, want grant=%h sel=%0d valid=%b out=%b",
                     grant, sel, valid, out, eg, es, ev, eo);
        end
        release_i = 1'b0; req = 8'h00;
        $display("test_v6 done");
    endtask

    initial begin
        rst = 1'b1; req = 8'h00; release_i = 1'b0; in = 8'h00;
        test_reset();
        test_v1();
        test_v2();
        test_v3();
        test_v4();
        test_v5();
        test_v6();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Parameters
REQ-001 The block SHALL have parameter MAX_HOLD, default 16, which is the maximum number of consecutive cycles one grant may last (legal range 1..256).

Interface
REQ-002 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  8  request vector; bit i is requester i.
REQ-006 release  input  1  current owner finished; sampled only in GRANT.
REQ-007 in  input  8  data bits; bit i belongs to requester i.
REQ-008 grant  output  8  one-hot grant, registered; all-zero when no owner.
REQ-009 sel  output  3  registered index of current or last owner; drives the 2:1-tree 8:1 mux select.
REQ-010 valid  output  1  registered; 1 while in GRANT.
REQ-011 out  output  1  combinational; equals in[sel] when valid=1, else 0.

Function
REQ-012 The block SHALL implement two states: IDLE and GRANT.
REQ-013 Internal state SHALL comprise: last[2:0] (last granted index), hold_cnt[7:0], and the state register.
REQ-014 IDLE behaviour:
- Outputs grant=0 and valid=0; sel holds its previous value.
- If req!=0 at a clock edge, the block SHALL move to GRANT.
- At that edge: grant=onehot(w), sel=w, valid=1, last=w, hold_cnt=0.
REQ-015 w SHALL be the first set req bit in the search order last+1, last+2, ..., last+8 (mod 8).
- Round-robin: the previous owner has the lowest priority.
REQ-016 Grant latency SHALL be exactly one cycle, from the req sample in IDLE to valid=1.
REQ-017 In GRANT, hold_cnt SHALL increment by 1 on each edge where the grant does not terminate.
REQ-018 The grant SHALL terminate at an edge where any of these hold:
- release=1;
- req[sel]=0;
- hold_cnt==MAX_HOLD-1.
REQ-019 On termination the block SHALL go to IDLE with grant=0 and valid=0 at that edge; sel and last are unchanged.
REQ-020 Back-to-back grants SHALL be separated by exactly one IDLE cycle.
- Minimum grant length is 1 cycle; maximum is MAX_HOLD cycles.
REQ-021 With MAX_HOLD=1, every grant SHALL last exactly one cycle.
REQ-022 release SHALL be ignored in IDLE.
REQ-023 Changes to req bits other than req[sel] during GRANT SHALL not affect the current grant.
REQ-024 If termination and new requests coincide, the block SHALL still enter IDLE; arbitration happens in the following cycle.
REQ-025 grant SHALL always be one-hot or zero.
REQ-026 grant SHALL equal onehot(sel) whenever valid=1.

Reset
REQ-027 On an edge with rst=1 the block SHALL set, from any state including mid-grant: state=IDLE, grant=0, valid=0, sel=0, last=7, hold_cnt=0.
REQ-028 The reset value last=7 SHALL make the first search after reset start at requester 0.
REQ-029 rst SHALL take priority over all other inputs.

Verification
REQ-030 Directed scenarios the bench SHALL cover:
- V1: reset, then req=8'h01, in=8'h01 -> one edge later grant=8'h01, sel=0, valid=1, out=1.
- V2: MAX_HOLD=4, req=8'hFF held, release=0 -> grants to 0,1,...,7,0, each valid for 4 cycles, with 1 idle cycle between grants.
- V3: requester 3 owns the grant; req[3] drops on cycle 2 of the grant -> next edge grant=0, valid=0; the following edge grants the next requester after 3.
- V4: after reset, req=8'h81 held, release pulsed once per grant -> grant order 0, 7, 0, 7.
- V5: rst=1 while in GRANT with sel=5 -> next edge grant=0, valid=0, sel=0, out=0; with req=8'hFF afterwards, the first grant goes to 0.
- V6: release=1 and new req bits rise on the same edge -> exactly one IDLE cycle, then a grant to the round-robin winner; out tracks in[sel] throughout valid.
